lcd_bus_responder: RTL and testbench

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_bus_responder_if.sv | 19 +
 rtl/lcd_en_sync.sv | 31 +++
 rtl/lcd_bus_responder.sv | 149 ++++++++++++++
 tb/tb_lcd_bus_responder.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared opcodes, state encoding and helpers for the character-LCD bus responder.
package lcd_pkg;

    localparam logic [7:0] OP_FUNC_SET   = 8'h30;
    localparam logic [7:0] OP_ENTRY_MODE = 8'h06;
    localparam logic [7:0] OP_CLEAR      = 8'h01;
    localparam logic [7:0] OP_DISP_CTRL  = 8'h0C;
    localparam logic [7:0] OP_HOME       = 8'h02;
    localparam logic [7:0] OP_SET_ADDR   = 8'h80;

    // Instructions are decoded by their leading one; these are those bits.
    localparam logic [7:0] MASK_SET_ADDR   = OP_SET_ADDR;
    localparam logic [7:0] MASK_FUNC_SET   = OP_FUNC_SET & 8'hE0;
    localparam logic [7:0] MASK_DISP_CTRL  = OP_DISP_CTRL & 8'hF8;
    localparam logic [7:0] MASK_ENTRY_MODE = OP_ENTRY_MODE & 8'hFC;
    localparam logic [7:0] MASK_HOME       = OP_HOME & 8'hFE;
    localparam logic [7:0] MASK_CLEAR      = OP_CLEAR;

    localparam logic [7:0] SPACE       = 8'h20;
    localparam int         DDRAM_DEPTH = 32;
    localparam int         AC_W        = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    function automatic logic [7:0] lead_one(input logic [7:0] d);
        lead_one = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) lead_one = 8'h01 << i;
        end
    endfunction

    // Byte index is {line, column[2:0], half}.
    function automatic logic [AC_W-1:0] set_addr(input logic [7:0] d);
        set_addr = {d[4], d[2:0], 1'b0};
    endfunction

    function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac, input logic inc);
        ac_step = inc ? ac + 1'b1 : ac - 1'b1;
    endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// Parallel LCD bus as seen between an MCU (master) and the responder (slave).
interface lcd_bus_responder_if;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [7:0] LCD_Data_in;
    logic [7:0] LCD_Data_out;
    logic       LCD_Data_oe;

    modport master (
        output LCD_RS, LCD_RW, LCD_EN, LCD_Data_in,
        input  LCD_Data_out, LCD_Data_oe
    );

    modport slave (
        input  LCD_RS, LCD_RW, LCD_EN, LCD_Data_in,
        output LCD_Data_out, LCD_Data_oe
    );
endinterface

// File: rtl/lcd_en_sync.sv
// Multi-flop synchronizer for the asynchronous LCD_EN strobe plus falling-edge detect.
module lcd_en_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_async,
    output logic en_sync,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(en_async);
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign en_sync = sync_q[STAGES-1];
    assign fall    = prev_q & ~en_sync;
endmodule

// File: rtl/lcd_bus_responder.sv
// Character-LCD controller bus model: decodes bus cycles into a 32-byte DDRAM,
// address counter, display-on bit and busy/overrun status.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES = 72,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    lcd_bus_responder_if.slave bus,
    input  logic [AC_W-1:0]   rd_addr,
    output logic [7:0]        rd_data,
    output logic              disp_on,
    output logic              busy,
    output logic              overrun
);
    // state    | meaning
    // ST_IDLE  | ready, bus writes execute
    // ST_EXEC  | busy down-counter running after an executed write
    // ST_CLEAR | filling DDRAM with SPACE, one byte per cycle

    localparam int            CNT_W    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AC_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [AC_W-1:0]   ac_q, ac_d;
    logic              inc_q, inc_d;
    logic              disp_on_q, disp_on_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        ddram_q [DDRAM_DEPTH];
    logic [7:0]        ddram_d [DDRAM_DEPTH];

    logic              en_sync;
    logic              strobe;
    logic              busy_w;
    logic [7:0]        lead;

    lcd_en_sync #(.STAGES(SYNC_STAGES)) u_en_sync (
        .clk      (clk),
        .rst      (rst),
        .en_async (bus.LCD_EN),
        .en_sync  (en_sync),
        .fall     (strobe)
    );

    assign busy_w = (state_q != ST_IDLE);
    assign lead   = lead_one(bus.LCD_Data_in);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_ptr_d = clr_ptr_q;
        ac_d      = ac_q;
        inc_d     = inc_q;
        disp_on_d = disp_on_q;
        overrun_d = overrun_q;
        dout_d    = dout_q;
        ddram_d   = ddram_q;
        rd_data_d = ddram_q[rd_addr];

        if (en_sync && bus.LCD_RW) begin
            dout_d = bus.LCD_RS ? ddram_q[ac_q] : {busy_w, 2'b00, ac_q};
        end

        if (strobe) begin
            if (bus.LCD_RW) begin
                if (bus.LCD_RS) ac_d = ac_step(ac_q, inc_q);
            end else if (busy_w) begin
                overrun_d = 1'b1;
            end else if (bus.LCD_RS) begin
                ddram_d[ac_q] = bus.LCD_Data_in;
                ac_d          = ac_step(ac_q, inc_q);
                state_d       = ST_EXEC;
                cnt_d         = CNT_LOAD;
            end else if (lead != 8'h00) begin
                state_d = ST_EXEC;
                cnt_d   = CNT_LOAD;
                case (lead)
                    MASK_SET_ADDR:   ac_d      = set_addr(bus.LCD_Data_in);
                    MASK_DISP_CTRL:  disp_on_d = bus.LCD_Data_in[2];
                    MASK_ENTRY_MODE: inc_d     = bus.LCD_Data_in[1];
                    MASK_HOME:       ac_d      = '0;
                    MASK_CLEAR: begin
                        state_d   = ST_CLEAR;
                        clr_ptr_d = '0;
                    end
                    default: ;
                endcase
            end
        end

        // A write is never accepted outside IDLE, so these cannot collide with it.
        case (state_q)
            ST_EXEC: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_CLEAR: begin
                ddram_d[clr_ptr_q] = SPACE;
                clr_ptr_d          = clr_ptr_q + 1'b1;
                if (clr_ptr_q == AC_W'(DDRAM_DEPTH - 1)) begin
                    state_d = ST_EXEC;
                    cnt_d   = CNT_LOAD;
                    ac_d    = '0;
                    inc_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            clr_ptr_q <= '0;
            ac_q      <= '0;
            inc_q     <= 1'b1;
            disp_on_q <= 1'b0;
            overrun_q <= 1'b0;
            dout_q    <= 8'h00;
            rd_data_q <= SPACE;
            ddram_q   <= '{default: SPACE};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_ptr_q <= clr_ptr_d;
            ac_q      <= ac_d;
            inc_q     <= inc_d;
            disp_on_q <= disp_on_d;
            overrun_q <= overrun_d;
            dout_q    <= dout_d;
            rd_data_q <= rd_data_d;
            ddram_q   <= ddram_d;
        end
    end

    assign bus.LCD_Data_out = dout_q;
    assign bus.LCD_Data_oe  = en_sync & bus.LCD_RW;
    assign rd_data          = rd_data_q;
    assign disp_on          = disp_on_q;
    assign busy             = busy_w;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scoreboard bench for lcd_bus_responder: bus writes/reads and host-port reads.
module tb_lcd_bus_responder;
    import lcd_pkg::*;

    localparam int BUSY = 72;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       disp_on, busy, overrun;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] exp_q[$];

    lcd_bus_responder_if bus();

    lcd_bus_responder #(.BUSY_CYCLES(BUSY), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .disp_on (disp_on),
        .busy    (busy),
        .overrun (overrun)
    );

    always #10 clk = ~clk;

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Bus write; when wait_busy is set, len returns how many cycles busy was high (0 if it never rose).
    task automatic bus_write(input logic rs, input logic [7:0] d, input bit wait_busy, output int len);
        int w;
        @(negedge clk);
        bus.LCD_RS = rs; bus.LCD_RW = 1'b0; bus.LCD_Data_in = d; bus.LCD_EN = 1'b1;
        repeat (4) @(negedge clk);
        bus.LCD_EN = 1'b0;
        len = 0;
        if (!wait_busy) begin
            repeat (4) @(negedge clk);
        end else begin
            w = 0;
            while (busy !== 1'b1 && w < 10) begin @(negedge clk); w++; end
            while (busy === 1'b1 && len < 400) begin @(negedge clk); len++; end
        end
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe);
        @(negedge clk);
        bus.LCD_RS = rs; bus.LCD_RW = 1'b1; bus.LCD_EN = 1'b1;
        repeat (4) @(negedge clk);
        d  = bus.LCD_Data_out;
        oe = bus.LCD_Data_oe;
        bus.LCD_EN = 1'b0;
        repeat (4) @(negedge clk);
        bus.LCD_RW = 1'b0;
    endtask

    task automatic host_read(input logic [4:0] a, output logic [7:0] d);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic test_reset;
        logic [7:0] got, want;
        logic       oe;
        bus.LCD_EN = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_Data_in = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, overrun, disp_on, bus.LCD_Data_oe} !== 4'b0000) begin
            n_miss++; $display("FAIL reset_flags got=%b want=0000", {busy, overrun, disp_on, bus.LCD_Data_oe});
        end
        n_vec++;
        if (bus.LCD_Data_out !== 8'h00) begin
            n_miss++; $display("FAIL reset_dout got=%h want=00", bus.LCD_Data_out);
        end
        for (int i = 0; i < 32; i += 31) begin
            exp_q.push_back(SPACE);
            host_read(5'(i), got);
            want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_miss++; $display("FAIL reset_ddram[%0d] got=%h want=%h", i, got, want); end
        end
        exp_q.push_back(8'h00);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want || oe !== 1'b1) begin
            n_miss++; $display("FAIL reset_status got=%h oe=%b want=%h oe=1", got, oe, want);
        end
    endtask

    task automatic test_init_sequence;
        logic [7:0] ops [8] = '{8'h30, 8'h06, 8'h01, 8'h0C, 8'h02, 8'hC0, 8'hB0, 8'hD9};
        int         lens[8] = '{BUSY, BUSY, 32 + BUSY, BUSY, BUSY, BUSY, BUSY, BUSY};
        int         len;
        logic [7:0] got, want;
        logic       oe;
        for (int i = 0; i < 8; i++) begin
            bus_write(i >= 6, ops[i], 1'b1, len);
            n_vec++;
            if (len != lens[i]) begin
                n_miss++; $display("FAIL init_busy_len op=%h got=%0d want=%0d", ops[i], len, lens[i]);
            end
        end
        bus_write(1'b0, 8'h00, 1'b1, len);
        n_vec++;
        if (len != 0) begin n_miss++; $display("FAIL nop_busy_len got=%0d want=0", len); end
        exp_q.push_back(8'hB0); exp_q.push_back(8'hD9);
        for (int i = 0; i < 2; i++) begin
            host_read(5'(i), got);
            want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_miss++; $display("FAIL init_ddram[%0d] got=%h want=%h", i, got, want); end
        end
        exp_q.push_back(8'h02);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL init_status got=%h want=%h", got, want); end
        n_vec++;
        if ({disp_on, overrun} !== 2'b10) begin
            n_miss++; $display("FAIL init_flags disp_on,overrun got=%b want=10", {disp_on, overrun});
        end
    endtask

    task automatic test_set_addr;
        int         len;
        logic [7:0] got, want;
        logic       oe;
        bus_write(1'b0, 8'hD1, 1'b1, len);
        bus_write(1'b1, 8'h41, 1'b1, len);
        exp_q.push_back(8'h41);
        host_read(5'd18, got);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL setaddr_ddram[18] got=%h want=%h", got, want); end
        exp_q.push_back(8'h13);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL setaddr_status got=%h want=%h", got, want); end
    endtask

    task automatic test_wrap;
        int         len;
        logic [7:0] got, want;
        logic       oe;
        logic [4:0] addrs[3] = '{5'd30, 5'd31, 5'd0};
        bus_write(1'b0, 8'hD7, 1'b1, len);
        for (int i = 0; i < 3; i++) begin
            bus_write(1'b1, 8'hA1 + 8'(i), 1'b1, len);
            exp_q.push_back(8'hA1 + 8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            host_read(addrs[i], got);
            want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_miss++; $display("FAIL wrap_ddram[%0d] got=%h want=%h", addrs[i], got, want); end
        end
        exp_q.push_back(8'h01);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL wrap_up_status got=%h want=%h", got, want); end
        bus_write(1'b0, 8'h80, 1'b1, len);
        bus_write(1'b0, 8'h04, 1'b1, len);
        bus_write(1'b1, 8'h5A, 1'b1, len);
        exp_q.push_back(8'h5A);
        host_read(5'd0, got);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL wrap_dec_ddram[0] got=%h want=%h", got, want); end
        exp_q.push_back(8'h1F);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL wrap_down_status got=%h want=%h", got, want); end
        bus_write(1'b0, 8'h06, 1'b1, len);
    endtask

    task automatic test_data_read;
        int         len;
        logic [7:0] got, want;
        logic       oe;
        bus_write(1'b0, 8'hC0, 1'b1, len);
        exp_q.push_back(8'h5A); exp_q.push_back(8'hD9);
        for (int i = 0; i < 2; i++) begin
            bus_read(1'b1, got, oe);
            want = exp_q.pop_front(); n_vec++;
            if (got !== want || oe !== 1'b1) begin
                n_miss++; $display("FAIL data_read[%0d] got=%h oe=%b want=%h oe=1", i, got, oe, want);
            end
        end
        n_vec++;
        if (bus.LCD_Data_oe !== 1'b0) begin n_miss++; $display("FAIL data_read_oe_idle got=%b want=0", bus.LCD_Data_oe); end
        exp_q.push_back(8'h02);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL data_read_status got=%h want=%h", got, want); end
    endtask

    task automatic test_clear;
        int         len;
        logic [7:0] got, want;
        logic       oe;
        bus_write(1'b0, 8'h80, 1'b1, len);
        for (int i = 0; i < 32; i++) bus_write(1'b1, 8'h55, 1'b1, len);
        exp_q.push_back(8'h55);
        host_read(5'd7, got);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL fill_ddram[7] got=%h want=%h", got, want); end
        bus_write(1'b0, 8'h01, 1'b1, len);
        n_vec++;
        if (len != 32 + BUSY) begin n_miss++; $display("FAIL clear_busy_len got=%0d want=%0d", len, 32 + BUSY); end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(SPACE);
            host_read(5'(i), got);
            want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_miss++; $display("FAIL clear_ddram[%0d] got=%h want=%h", i, got, want); end
        end
        exp_q.push_back(8'h00);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL clear_status got=%h want=%h", got, want); end
    endtask

    task automatic test_overrun;
        int         len, w;
        logic [7:0] got, want;
        logic       oe;
        bus_write(1'b0, 8'h80, 1'b0, len);
        bus_write(1'b1, 8'h77, 1'b0, len);
        exp_q.push_back(8'h80);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL overrun_busy_status got=%h want=%h", got, want); end
        n_vec++;
        if (overrun !== 1'b1) begin n_miss++; $display("FAIL overrun_flag got=%b want=1", overrun); end
        w = 0;
        while (busy === 1'b1 && w < 200) begin @(negedge clk); w++; end
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL overrun_busy_timeout got=%b want=0", busy); end
        exp_q.push_back(SPACE);
        host_read(5'd0, got);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL overrun_ddram[0] got=%h want=%h", got, want); end
        exp_q.push_back(8'h00);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL overrun_status got=%h want=%h", got, want); end
    endtask

    task automatic test_reset_during_clear;
        int         len;
        logic [7:0] got, want;
        logic       oe;
        bus_write(1'b0, 8'h92, 1'b1, len);
        bus_write(1'b1, 8'h33, 1'b1, len);
        exp_q.push_back(8'h33);
        host_read(5'd20, got);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL pre_rst_ddram[20] got=%h want=%h", got, want); end
        bus_write(1'b0, 8'h01, 1'b0, len);
        repeat (9) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin n_miss++; $display("FAIL clear_in_progress got=%b want=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_abort_busy got=%b want=0", busy); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, overrun, disp_on} !== 3'b000) begin
            n_miss++; $display("FAIL rst_flags got=%b want=000", {busy, overrun, disp_on});
        end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(SPACE);
            host_read(5'(i), got);
            want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_miss++; $display("FAIL rst_ddram[%0d] got=%h want=%h", i, got, want); end
        end
        exp_q.push_back(8'h00);
        bus_read(1'b0, got, oe);
        want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL rst_status got=%h want=%h", got, want); end
    endtask

    initial begin
        test_reset();
        test_init_sequence();
        test_set_addr();
        test_wrap();
        test_data_read();
        test_clear();
        test_overrun();
        test_reset_during_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
